// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard with RAW/WAW/fence interlock
//
// Tracks in-flight register writes with one saturating counter per register
// (x0 excluded) and gates issue of the decoded instruction on read-after-write
// hazards, counter saturation and fences. A fence with writes in flight parks
// the FSM in DRAIN until every outstanding write has retired.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   dec_*                 decoded instruction and its operand-use flags
//   ex_ready              execute stage can accept this cycle
//   wb_valid, wb_rd       register write retiring this cycle
//   flush                 pipeline squash, clears all tracking
//   issue, stall          instruction accepted / hold fetch-decode
//   pending               bit i set while register i has writes in flight
//   outstanding           total writes in flight
//   draining              FSM waiting for a fence to drain
//   underflow_err         sticky: a writeback retired with nothing pending
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic [4:0]          dec_rd,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic                dec_wr_rd,
  input  logic                dec_fence,
  input  logic                ex_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic                issue,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending,
  output logic [6:0]          outstanding,
  output logic                draining,
  output logic                underflow_err
);

  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];
  logic [0:0]       state_q, state_d;
  logic             underflow_q, underflow_d;

  // Full 32-entry view indexed directly by 5-bit register numbers; x0 and
  // any register beyond NUM_REGS read as zero.
  logic [CNT_W-1:0] cnt_all [32];
  logic             raw;
  logic             waw_full;

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_all[i] = '0;
    for (int i = 1; i < NUM_REGS; i++) cnt_all[i] = cnt_q[i];
  end

  always_comb begin
    outstanding = '0;
    pending     = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      outstanding = outstanding + 7'(cnt_q[i]);
      pending[i]  = |cnt_q[i];
    end
  end

  // Hazards look only at registered counters: a write retiring this cycle
  // releases its consumer one cycle later.
  always_comb begin
    raw = (dec_use_rs1 && dec_rs1 != 5'd0 && cnt_all[dec_rs1] != '0) ||
          (dec_use_rs2 && dec_rs2 != 5'd0 && cnt_all[dec_rs2] != '0);
    waw_full = dec_wr_rd && dec_rd != 5'd0 && cnt_all[dec_rd] == CNT_MAX;
  end

  assign issue = (state_q == ST_RUN) && dec_valid && ex_ready && !raw && !waw_full &&
                 !flush && !(dec_fence && outstanding != 7'd0);
  assign stall         = dec_valid && !issue;
  assign draining      = (state_q == ST_DRAIN);
  assign underflow_err = underflow_q;

  always_comb begin
    logic inc;
    logic dec;
    cnt_d       = cnt_q;
    state_d     = state_q;
    underflow_d = underflow_q;
    inc         = 1'b0;
    dec         = 1'b0;
    if (flush) begin
      for (int i = 1; i < NUM_REGS; i++) cnt_d[i] = '0;
      state_d = ST_RUN;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        inc = issue && dec_wr_rd && (dec_rd == 5'(i));
        dec = wb_valid && (wb_rd == 5'(i));
        // Simultaneous issue and retire on one register cancel out.
        if (inc && !dec) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (dec && !inc) begin
          if (cnt_q[i] == '0) underflow_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      if (state_q == ST_RUN) begin
        if (dec_valid && dec_fence && outstanding != 7'd0) state_d = ST_DRAIN;
      end else begin
        if (outstanding == 7'd0) state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) cnt_q[i] <= '0;
      state_q     <= ST_RUN;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
